// File: rtl/apb_v4_sram_if.sv
// APB4 bus bundle between the bridge (master) and the SRAM slave.
interface apb_v4_sram_if #(
  parameter int ADDR_BUS_WIDTH = 32,
  parameter int DATA_BUS_WIDTH = 32
);
  logic                          PSEL;
  logic                          PENABLE;
  logic                          PWRITE;
  logic [ADDR_BUS_WIDTH-1:0]     PADDR;
  logic [DATA_BUS_WIDTH-1:0]     PWDATA;
  logic [DATA_BUS_WIDTH/8-1:0]   PSTRB;
  logic [DATA_BUS_WIDTH-1:0]     PRDATA;
  logic                          PREADY;
  logic                          PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_v4_sram.sv
// APB4 slave SRAM: byte-strobed word memory, counted wait states and
// alignment/range error reporting, all synchronous to PCLK.
module apb_v4_sram #(
  parameter int          ADDR_BUS_WIDTH  = 32,
  parameter int          DATA_BUS_WIDTH  = 32,
  parameter int          MEM_DEPTH       = 64,
  parameter logic [7:0]  RESET_VAL       = 8'h00,
  parameter int          WAIT_CYCLES     = 0,
  parameter bit          ERR_ON_MISALIGN = 1'b1
) (
  input  logic         PCLK,
  input  logic         PRESETn,
  apb_v4_sram_if.slave bus
);

  localparam int BYTES = DATA_BUS_WIDTH / 8;
  localparam int SH    = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_BUS_WIDTH:0] LIMIT = (ADDR_BUS_WIDTH + 1)'(MEM_DEPTH * BYTES);
  localparam logic [4:0] WAIT_TGT = 5'(WAIT_CYCLES);
  localparam logic [DATA_BUS_WIDTH-1:0] RST_WORD = {BYTES{RESET_VAL}};

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                      state;
  state_t                      phase;
  logic [3:0]                  cnt;
  logic [4:0]                  cnt_inc;
  logic                        pready_q;
  logic                        pslverr_q;
  logic [DATA_BUS_WIDTH-1:0]   prdata_q;
  logic [DATA_BUS_WIDTH-1:0]   mem [MEM_DEPTH];

  logic                        out_of_range;
  logic                        misaligned;
  logic                        addr_err;
  logic                        load_resp;
  logic [IW-1:0]               word_idx;
  logic [DATA_BUS_WIDTH-1:0]   rd_word;

  assign out_of_range = ({1'b0, bus.PADDR} >= LIMIT);

  generate
    if (BYTES > 1) begin : g_align
      assign misaligned = ERR_ON_MISALIGN && (bus.PADDR[SH-1:0] != '0);
    end else begin : g_noalign
      assign misaligned = 1'b0;
    end
  endgenerate

  assign addr_err = out_of_range || misaligned;
  assign word_idx = IW'(bus.PADDR >> SH);
  assign rd_word  = mem[word_idx];
  assign cnt_inc  = {1'b0, cnt} + 5'd1;

  // The setup cycle is decoded from the bus while idle, so the edge that
  // ends it already starts the access phase and no idle gap appears.
  always_comb begin
    phase = state;
    if (state == IDLE && bus.PSEL && !bus.PENABLE) begin
      phase = SETUP;
    end
  end

  assign load_resp = (phase == SETUP && WAIT_CYCLES == 0) ||
                     (phase == ACCESS && !pready_q && bus.PSEL && bus.PENABLE &&
                      cnt_inc == WAIT_TGT);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      cnt       <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      for (int w = 0; w < MEM_DEPTH; w++) begin
        mem[w] <= RST_WORD;
      end
    end else begin
      if (load_resp) begin
        pslverr_q <= addr_err;
        if (!bus.PWRITE) begin
          prdata_q <= addr_err ? '0 : rd_word;
        end
      end
      case (phase)
        SETUP: begin
          state    <= ACCESS;
          cnt      <= '0;
          pready_q <= (WAIT_CYCLES == 0);
        end
        ACCESS: begin
          if (!bus.PSEL) begin
            state     <= IDLE;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
          end else if (bus.PENABLE) begin
            if (pready_q) begin
              state     <= IDLE;
              pready_q  <= 1'b0;
              pslverr_q <= 1'b0;
              // Writes land only at completion, one byte lane per strobe bit.
              if (bus.PWRITE && !addr_err) begin
                for (int b = 0; b < BYTES; b++) begin
                  if (bus.PSTRB[b]) begin
                    mem[word_idx][b*8 +: 8] <= bus.PWDATA[b*8 +: 8];
                  end
                end
              end
            end else begin
              cnt      <= cnt_inc[3:0];
              pready_q <= (cnt_inc == WAIT_TGT);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.PREADY  = pready_q;
  assign bus.PSLVERR = pslverr_q;
  assign bus.PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_v4_sram.sv
// Directed plus randomized bench for apb_v4_sram; two instances cover
// zero-wait/strict-alignment and wait-state/relaxed-alignment builds.
module tb_apb_v4_sram;

  logic        PCLK;
  logic        rst_n0;
  logic        rst_n1;
  int          sel;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int tests_run;
  int tests_failed;

  logic [31:0] model [2][64];
  int          wc    [2] = '{0, 3};
  bit          mis   [2] = '{1'b1, 1'b0};
  logic [7:0]  rstv  [2] = '{8'hA5, 8'h3C};

  apb_v4_sram_if #(.ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(32)) if0 ();
  apb_v4_sram_if #(.ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(32)) if1 ();

  apb_v4_sram #(
    .ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(32), .MEM_DEPTH(64),
    .RESET_VAL(8'hA5), .WAIT_CYCLES(0), .ERR_ON_MISALIGN(1'b1)
  ) u_dut0 (.PCLK(PCLK), .PRESETn(rst_n0), .bus(if0.slave));

  apb_v4_sram #(
    .ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(32), .MEM_DEPTH(64),
    .RESET_VAL(8'h3C), .WAIT_CYCLES(3), .ERR_ON_MISALIGN(1'b0)
  ) u_dut1 (.PCLK(PCLK), .PRESETn(rst_n1), .bus(if1.slave));

  assign if0.PSEL    = psel && (sel == 0);
  assign if1.PSEL    = psel && (sel == 1);
  assign if0.PENABLE = penable;
  assign if1.PENABLE = penable;
  assign if0.PWRITE  = pwrite;
  assign if1.PWRITE  = pwrite;
  assign if0.PADDR   = paddr;
  assign if1.PADDR   = paddr;
  assign if0.PWDATA  = pwdata;
  assign if1.PWDATA  = pwdata;
  assign if0.PSTRB   = pstrb;
  assign if1.PSTRB   = pstrb;

  assign prdata  = (sel == 1) ? if1.PRDATA  : if0.PRDATA;
  assign pready  = (sel == 1) ? if1.PREADY  : if0.PREADY;
  assign pslverr = (sel == 1) ? if1.PSLVERR : if0.PSLVERR;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  function automatic bit addr_error(int d, logic [31:0] a);
    return (a >= 32'd256) || (mis[d] && (a[1:0] != 2'b00));
  endfunction

  task automatic reset_model(int d);
    for (int w = 0; w < 64; w++) model[d][w] = {4{rstv[d]}};
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete APB transfer; leaves PSEL high afterwards when hold is set.
  task automatic applyStimulus(input int d, input bit wr, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] st, input bit hold,
                               output logic [31:0] rd, output logic err, output int lat);
    sel = d; psel = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    @(posedge PCLK); #1;
    penable = 1'b1;
    lat = 1;
    while (pready !== 1'b1 && lat < 40) begin
      @(posedge PCLK); #1;
      lat++;
    end
    rd = prdata; err = pslverr;
    @(posedge PCLK); #1;
    penable = 1'b0;
    if (!hold) psel = 1'b0;
    if (wr && !addr_error(d, a)) begin
      for (int b = 0; b < 4; b++)
        if (st[b]) model[d][a[7:2]][b*8 +: 8] = wd[b*8 +: 8];
    end
  endtask

  task automatic xfer(input string tag, input int d, input bit wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] st, input bit hold);
    logic [31:0] rd, exp_rd;
    logic        err, exp_err;
    int          lat;
    exp_err = addr_error(d, a);
    exp_rd  = exp_err ? 32'h0 : model[d][a[7:2]];
    applyStimulus(d, wr, a, wd, st, hold, rd, err, lat);
    checkOutput({tag, "/latency"}, 64'(lat), 64'(1 + wc[d]));
    checkOutput({tag, "/pslverr"}, 64'(err), 64'(exp_err));
    if (!wr) checkOutput({tag, "/prdata"}, 64'(rd), 64'(exp_rd));
    checkOutput({tag, "/pready_done"}, 64'(pready), 64'(1'b0));
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    sel = 0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    reset_model(0); reset_model(1);

    // Bus activity while held in reset must never raise PREADY.
    for (int c = 0; c < 4; c++) begin
      psel = 1'b1; penable = c[0]; paddr = 32'h10;
      @(posedge PCLK); #1;
      checkOutput("reset/pready0", 64'(if0.PREADY), 64'(1'b0));
      checkOutput("reset/pready1", 64'(if1.PREADY), 64'(1'b0));
    end
    checkOutput("reset/pslverr0", 64'(if0.PSLVERR), 64'(1'b0));
    checkOutput("reset/prdata0", 64'(if0.PRDATA), 64'h0);
    psel = 1'b0; penable = 1'b0;
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    @(posedge PCLK); #1;

    xfer("rst_read_0x00", 0, 1'b0, 32'h00, 32'h0, 4'h0, 1'b0);
    xfer("rst_read_0xFC", 0, 1'b0, 32'hFC, 32'h0, 4'h0, 1'b0);
    checkOutput("rst_read_0xFC/const", 64'(prdata), 64'h0000_0000_A5A5_A5A5);

    xfer("b2b_write", 0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    xfer("b2b_read",  0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);

    xfer("strb_full", 0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0);
    xfer("strb_0101", 0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0);
    xfer("strb_none", 0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 1'b0);
    xfer("strb_read", 0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
    checkOutput("strb_read/const", 64'(prdata), 64'h0000_0000_11BB_33DD);

    xfer("err_wr_0x100",  0, 1'b1, 32'h100, 32'h12345678, 4'hF, 1'b0);
    xfer("err_chk_0x00",  0, 1'b0, 32'h00, 32'h0, 4'h0, 1'b0);
    xfer("err_rd_0x102",  0, 1'b0, 32'h102, 32'h0, 4'h0, 1'b0);
    xfer("err_rd_0x12",   0, 1'b0, 32'h12, 32'h0, 4'h0, 1'b0);

    xfer("wait_read_0x04", 1, 1'b0, 32'h04, 32'h0, 4'h0, 1'b0);
    xfer("nomis_rd_0x102", 1, 1'b0, 32'h102, 32'h0, 4'h0, 1'b0);
    xfer("nomis_wr_0x10",  1, 1'b1, 32'h10, 32'h0BADF00D, 4'hF, 1'b0);
    xfer("nomis_rd_0x12",  1, 1'b0, 32'h12, 32'h0, 4'h0, 1'b0);
    checkOutput("nomis_rd_0x12/const", 64'(prdata), 64'h0000_0000_0BAD_F00D);

    // Abort: PSEL dropped after two wait cycles, write must not land.
    sel = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h30; pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge PCLK); #1; penable = 1'b1;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge PCLK); #1;
    checkOutput("abort/pready", 64'(pready), 64'(1'b0));
    checkOutput("abort/pslverr", 64'(pslverr), 64'(1'b0));
    xfer("abort_read_0x30", 1, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0);

    // Reset pulse in the middle of an access.
    sel = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h40; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    @(posedge PCLK); #1; penable = 1'b1;
    @(posedge PCLK); #2;
    rst_n1 = 1'b0;
    #1;
    checkOutput("rst_mid/pready", 64'(pready), 64'(1'b0));
    checkOutput("rst_mid/prdata", 64'(prdata), 64'h0);
    psel = 1'b0; penable = 1'b0;
    @(posedge PCLK); #1;
    rst_n1 = 1'b1;
    reset_model(1);
    @(posedge PCLK); #1;
    xfer("rst_mid_rd_0x40", 1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
    xfer("rst_mid_rd_0x10", 1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);

    for (int i = 0; i < 80; i++) begin
      int          d;
      bit          wr;
      logic [31:0] a;
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) a = 32'($urandom_range(0, 511));
      else                           a = 32'($urandom_range(0, 63)) << 2;
      xfer("random", d, wr, a, $urandom, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)));
    end
    psel = 1'b0;
    @(posedge PCLK); #1;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
